// File: rtl/full_feeder_if.sv
// Host, stream and status signals between full_feeder and its surroundings.
// master is the feeder's view; slave is the host / `full` side.
interface full_feeder_if #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int OUT_DEPTH = 4
);
  localparam int AW = $clog2((DEPTH > OUT_DEPTH) ? DEPTH : OUT_DEPTH);

  logic              load_wr;
  logic              load_sel;
  logic [AW-1:0]     load_addr;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic [7:0]        num_frames;

  logic [DATA_W-1:0] st_data;
  logic              st_data_fst;
  logic              st_data_vld;
  logic              st_data_rdy;

  logic [DATA_W-1:0] expected;
  logic              expected_fst;
  logic              expected_vld;
  logic              expected_rdy;

  logic [DATA_W-1:0] st_data_out;
  logic              st_data_out_fst;
  logic              st_data_out_vld;
  logic              st_data_out_rdy;

  logic              busy;
  logic              done;
  logic              fst_err;
  logic [7:0]        out_frames;

  modport master (
    input  load_wr, load_sel, load_addr, load_data, start, num_frames,
    input  st_data_rdy, expected_rdy,
    input  st_data_out, st_data_out_fst, st_data_out_vld,
    output st_data, st_data_fst, st_data_vld,
    output expected, expected_fst, expected_vld,
    output st_data_out_rdy, busy, done, fst_err, out_frames
  );

  modport slave (
    output load_wr, load_sel, load_addr, load_data, start, num_frames,
    output st_data_rdy, expected_rdy,
    output st_data_out, st_data_out_fst, st_data_out_vld,
    input  st_data, st_data_fst, st_data_vld,
    input  expected, expected_fst, expected_vld,
    input  st_data_out_rdy, busy, done, fst_err, out_frames
  );
endinterface

// File: rtl/full_feeder.sv
// Stimulus/result engine for `full`: replays loaded input and expected buffers
// as framed vld/rdy streams and checks framing of the returning result stream.
module full_feeder_src #(
  parameter int DATA_W = 32,
  parameter int N      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              run,
  input  logic [7:0]        nf,
  input  logic [DATA_W-1:0] mem [N],
  input  logic              rdy,
  output logic [DATA_W-1:0] dat,
  output logic              fst,
  output logic              vld
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [7:0]    frm;
  logic          wrap;
  logic          last;

  assign wrap    = (idx == IW'(N - 1));
  assign last    = wrap && (frm == nf - 8'd1);
  assign idx_nxt = wrap ? '0 : idx + 1'b1;

  // Output register always presents mem[idx]; it only moves on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      frm <= '0;
      dat <= '0;
      fst <= 1'b0;
      vld <= 1'b0;
    end else if (go) begin
      idx <= '0;
      frm <= '0;
      dat <= mem[0];
      fst <= 1'b1;
      vld <= 1'b1;
    end else if (!run) begin
      vld <= 1'b0;
    end else if (vld && rdy) begin
      if (last) begin
        vld <= 1'b0;
      end else begin
        idx <= idx_nxt;
        dat <= mem[idx_nxt];
        fst <= (idx_nxt == '0);
        if (wrap) frm <= frm + 8'd1;
      end
    end
  end
endmodule

module full_feeder #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  full_feeder_if.master bus
);
  localparam int IAW = $clog2(DEPTH);
  localparam int EAW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        nf;
  logic [EAW-1:0]    o_idx;
  logic [7:0]        frm_cnt;
  logic              err_flag;
  logic [DATA_W-1:0] ibuf [DEPTH];
  logic [DATA_W-1:0] ebuf [OUT_DEPTH];
  logic              idle_start;
  logic              go;
  logic              accept;
  logic              o_wrap;
  logic              last_out;
  logic              sink_rdy;
  logic              unused_data;

  // Result data is passed through unchecked; only framing matters here.
  assign unused_data = ^bus.st_data_out;

  assign idle_start = (state == IDLE) && bus.start;
  assign go         = idle_start && (bus.num_frames != 8'd0);
  assign accept     = sink_rdy && bus.st_data_out_vld;
  assign o_wrap     = (o_idx == EAW'(OUT_DEPTH - 1));
  assign last_out   = o_wrap && (frm_cnt == nf - 8'd1);

  always_comb begin
    state_nxt = state;
    sink_rdy  = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.num_frames == 8'd0) ? FLUSH : RUN;
      end
      RUN: begin
        sink_rdy = 1'b1;
        bus.busy = 1'b1;
        if (accept && last_out) state_nxt = FLUSH;
      end
      FLUSH: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      nf       <= '0;
      o_idx    <= '0;
      frm_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idle_start) begin
        nf       <= bus.num_frames;
        o_idx    <= '0;
        frm_cnt  <= '0;
        err_flag <= 1'b0;
      end else if (accept) begin
        o_idx <= o_wrap ? '0 : o_idx + 1'b1;
        if (o_wrap) frm_cnt <= frm_cnt + 8'd1;
        // No resync on a framing error: the index keeps counting blindly.
        if (bus.st_data_out_fst != (o_idx == '0)) err_flag <= 1'b1;
      end
    end
  end

  // Buffers survive reset so a run can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (bus.load_wr && (state == IDLE)) begin
      if (!bus.load_sel && (int'(bus.load_addr) < DEPTH))
        ibuf[bus.load_addr[IAW-1:0]] <= bus.load_data;
      if (bus.load_sel && (int'(bus.load_addr) < OUT_DEPTH))
        ebuf[bus.load_addr[EAW-1:0]] <= bus.load_data;
    end
  end

  assign bus.st_data_out_rdy = sink_rdy;
  assign bus.fst_err         = err_flag;
  assign bus.out_frames      = frm_cnt;

  full_feeder_src #(.DATA_W(DATA_W), .N(DEPTH)) u_in_src (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .run   (state_nxt == RUN),
    .nf    (nf),
    .mem   (ibuf),
    .rdy   (bus.st_data_rdy),
    .dat   (bus.st_data),
    .fst   (bus.st_data_fst),
    .vld   (bus.st_data_vld)
  );

  full_feeder_src #(.DATA_W(DATA_W), .N(OUT_DEPTH)) u_exp_src (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .run   (state_nxt == RUN),
    .nf    (nf),
    .mem   (ebuf),
    .rdy   (bus.expected_rdy),
    .dat   (bus.expected),
    .fst   (bus.expected_fst),
    .vld   (bus.expected_vld)
  );
endmodule

// File: tb/tb_full_feeder.sv
// Directed bench for full_feeder: replay, backpressure, empty run, framing
// error, mid-run reset and ignored host activity while busy.
module tb_full_feeder;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16;
  localparam int OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  full_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_DEPTH(OUT_DEPTH)) bus ();

  full_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [31:0] data);
    bus.load_wr   = 1'b1;
    bus.load_sel  = sel;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_wr = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] nf);
    bus.start      = 1'b1;
    bus.num_frames = nf;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] fmask);
    for (int k = 0; k < n; k++) begin
      chk("sink_rdy", bus.st_data_out_rdy, 1);
      bus.st_data_out_vld = 1'b1;
      bus.st_data_out_fst = fmask[k];
      bus.st_data_out     = 32'(200 + k);
      tick();
    end
    bus.st_data_out_vld = 1'b0;
    bus.st_data_out_fst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st_vld"},  bus.st_data_vld, 0);
    chk({tag, "_st_fst"},  bus.st_data_fst, 0);
    chk({tag, "_st_data"}, bus.st_data, 0);
    chk({tag, "_ex_vld"},  bus.expected_vld, 0);
    chk({tag, "_ex_fst"},  bus.expected_fst, 0);
    chk({tag, "_ex_data"}, bus.expected, 0);
    chk({tag, "_rdy"},     bus.st_data_out_rdy, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_done"},    bus.done, 0);
    chk({tag, "_fst_err"}, bus.fst_err, 0);
    chk({tag, "_frames"},  bus.out_frames, 0);
  endtask

  initial begin
    int w;
    bus.load_wr = 0; bus.load_sel = 0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 0; bus.num_frames = '0;
    bus.st_data_rdy = 1; bus.expected_rdy = 1;
    bus.st_data_out = '0; bus.st_data_out_fst = 0; bus.st_data_out_vld = 0;
    reset = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) wr(1'b0, 4'(i), 32'(i));
    for (int i = 0; i < OUT_DEPTH; i++) wr(1'b1, 4'(i), 32'(100 + i));
    wr(1'b1, 4'd5, 32'hDEAD);

    // Single frame, all ready: 16 input words and 4 expected words, no bubbles.
    start_run(8'd1);
    chk("t1_busy", bus.busy, 1);
    for (int i = 0; i < 20; i++) begin
      chk("t1_st_vld", bus.st_data_vld, (i < DEPTH));
      if (i < DEPTH) begin
        chk("t1_st_data", bus.st_data, 32'(i));
        chk("t1_st_fst", bus.st_data_fst, (i == 0));
      end
      chk("t1_ex_vld", bus.expected_vld, (i < OUT_DEPTH));
      if (i < OUT_DEPTH) begin
        chk("t1_ex_data", bus.expected, 32'(100 + i));
        chk("t1_ex_fst", bus.expected_fst, (i == 0));
      end
      tick();
    end
    feed(4, 32'h1);
    chk("t1_done", bus.done, 1);
    chk("t1_frames", bus.out_frames, 1);
    chk("t1_fst_err", bus.fst_err, 0);
    chk("t1_flush_rdy", bus.st_data_out_rdy, 0);
    tick();
    chk("t1_done_low", bus.done, 0);
    chk("t1_idle", bus.busy, 0);
    chk("t1_frames_final", bus.out_frames, 1);

    // Three frames with st_data_rdy toggling; held words are re-checked.
    start_run(8'd3);
    w = 0;
    for (int c = 0; c < 200 && w < 3 * DEPTH; c++) begin
      logic r;
      chk("t2_vld", bus.st_data_vld, 1);
      chk("t2_data", bus.st_data, 32'(w % DEPTH));
      chk("t2_fst", bus.st_data_fst, ((w % DEPTH) == 0));
      r = (c % 2 == 0);
      bus.st_data_rdy = r;
      tick();
      if (r) w++;
    end
    bus.st_data_rdy = 1'b1;
    chk("t2_count", 32'(w), 48);
    chk("t2_vld_end", bus.st_data_vld, 0);
    feed(12, 32'h111);
    chk("t2_done", bus.done, 1);
    chk("t2_frames", bus.out_frames, 3);
    chk("t2_fst_err", bus.fst_err, 0);
    tick();
    chk("t2_idle", bus.busy, 0);

    // Zero frames: straight to FLUSH, no stream activity.
    start_run(8'd0);
    chk("t3_busy", bus.busy, 1);
    chk("t3_done", bus.done, 1);
    chk("t3_st_vld", bus.st_data_vld, 0);
    chk("t3_ex_vld", bus.expected_vld, 0);
    chk("t3_rdy", bus.st_data_out_rdy, 0);
    tick();
    chk("t3_busy_low", bus.busy, 0);
    chk("t3_done_low", bus.done, 0);
    chk("t3_st_vld2", bus.st_data_vld, 0);

    // Return stream with fst on word 2 instead of word 0.
    start_run(8'd1);
    feed(4, 32'h4);
    chk("t4_done", bus.done, 1);
    chk("t4_fst_err", bus.fst_err, 1);
    chk("t4_frames", bus.out_frames, 1);
    tick();
    chk("t4_err_sticky", bus.fst_err, 1);
    chk("t4_idle", bus.busy, 0);

    // Reset at word 7 of frame 1; start must first clear the sticky error.
    start_run(8'd2);
    chk("t5_err_cleared", bus.fst_err, 0);
    for (int i = 0; i < DEPTH + 7; i++) begin
      bus.st_data_out_vld = (i < 5);
      bus.st_data_out_fst = (i == 4);
      tick();
    end
    bus.st_data_out_vld = 1'b0;
    bus.st_data_out_fst = 1'b0;
    chk("t5_word7_data", bus.st_data, 7);
    chk("t5_word7_fst", bus.st_data_fst, 0);
    chk("t5_word7_vld", bus.st_data_vld, 1);
    chk("t5_err", bus.fst_err, 1);
    chk("t5_frames", bus.out_frames, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5_rst");
    reset = 1'b0;
    tick();
    chk("t5_no_done", bus.done, 0);

    // Replay after reset; a write and a start while busy are both ignored.
    start_run(8'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t6_vld", bus.st_data_vld, 1);
      chk("t6_data", bus.st_data, 32'(i));
      chk("t6_fst", bus.st_data_fst, (i == 0));
      bus.load_wr    = (i == 3);
      bus.start      = (i == 3);
      bus.load_sel   = 1'b0;
      bus.load_addr  = 4'd10;
      bus.load_data  = 32'hAAAA;
      bus.num_frames = 8'd5;
      tick();
    end
    bus.load_wr = 1'b0;
    bus.start   = 1'b0;
    chk("t6_vld_end", bus.st_data_vld, 0);
    feed(4, 32'h1);
    chk("t6_done", bus.done, 1);
    chk("t6_frames", bus.out_frames, 1);
    tick();
    chk("t6_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
